// File: rtl/myrisc16_mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// myrisc16_mem_arbiter_if
//   Bundles the two requester ports and the block-RAM port of the myrisc16
//   memory arbiter.
//
//   Requester ports (p = 0 core, p = 1 PMOD loader / debug):
//     in_req<p>, in_we<p>, in_addr<p>, in_wdata<p>   request side
//     out_gnt<p>, out_rvalid<p>, out_rdata<p>        response side
//   RAM port:
//     out_mem_addr, out_mem_we, out_mem_wdata        to RAM
//     in_mem_rdata                                   from RAM (1-cycle latency)
//   Status:
//     out_conflicts                                  contention counter
//
//   Modports:
//     slave  - the arbiter itself
//     master - the surrounding system (requesters plus RAM)
// ---------------------------------------------------------------------------
interface myrisc16_mem_arbiter_if #(
  parameter int AW = 8,
  parameter int DW = 16
);
  logic          in_req0;
  logic          in_we0;
  logic [AW-1:0] in_addr0;
  logic [DW-1:0] in_wdata0;
  logic          out_gnt0;
  logic          out_rvalid0;
  logic [DW-1:0] out_rdata0;

  logic          in_req1;
  logic          in_we1;
  logic [AW-1:0] in_addr1;
  logic [DW-1:0] in_wdata1;
  logic          out_gnt1;
  logic          out_rvalid1;
  logic [DW-1:0] out_rdata1;

  logic [AW-1:0] out_mem_addr;
  logic          out_mem_we;
  logic [DW-1:0] out_mem_wdata;
  logic [DW-1:0] in_mem_rdata;

  logic [15:0]   out_conflicts;

  modport slave (
    input  in_req0, in_we0, in_addr0, in_wdata0,
    input  in_req1, in_we1, in_addr1, in_wdata1,
    input  in_mem_rdata,
    output out_gnt0, out_rvalid0, out_rdata0,
    output out_gnt1, out_rvalid1, out_rdata1,
    output out_mem_addr, out_mem_we, out_mem_wdata,
    output out_conflicts
  );

  modport master (
    output in_req0, in_we0, in_addr0, in_wdata0,
    output in_req1, in_we1, in_addr1, in_wdata1,
    output in_mem_rdata,
    input  out_gnt0, out_rvalid0, out_rdata0,
    input  out_gnt1, out_rvalid1, out_rdata1,
    input  out_mem_addr, out_mem_we, out_mem_wdata,
    input  out_conflicts
  );
endinterface

// File: rtl/myrisc16_mem_arbiter.sv
// ---------------------------------------------------------------------------
// myrisc16_mem_arbiter
//   Shares one synchronous single-port block RAM between the myrisc16 core
//   (port 0) and the PMOD program loader / debug port (port 1).
//
//   Ports:
//     in_clock       system clock, rising edge
//     in_reset       synchronous active-high reset
//     bus            myrisc16_mem_arbiter_if.slave (requesters, RAM, counter)
//     out_dbg_state  current FSM state (0 = IDLE, 1 = ACCESS)
//
//   Handshake: a requester raises in_req<p> with addr/we/wdata stable and
//   keeps them stable until out_gnt<p> has pulsed. The request is sampled in
//   IDLE (cycle N), the RAM access and out_gnt<p> happen in N+1, and a read
//   returns out_rvalid<p> with out_rdata<p> in N+2. In N+2 the requester
//   either drops in_req<p> or presents its next request, which is arbitrated
//   in that same cycle. There is no back-pressure on responses.
//
//   Arbitration: fixed priority to port 1 with a starvation override for
//   port 0 after STARVE_LIMIT consecutive lost contentions. Defining
//   MYRISC16_ARB_ROUND_ROBIN_EN replaces this with a 1-bit round-robin
//   pointer and removes the starvation counter.
// ---------------------------------------------------------------------------
module myrisc16_mem_arbiter #(
  parameter int AW           = 8,
  parameter int DW           = 16,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                  in_clock,
  input  logic                  in_reset,
  myrisc16_mem_arbiter_if.slave bus,
  output logic                  out_dbg_state
);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic          mem_we_q, mem_we_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          winner_q, winner_d;
  logic          rvalid0_q, rvalid0_d;
  logic          rvalid1_q, rvalid1_d;
  logic [DW-1:0] rdata0_q, rdata0_d;
  logic [DW-1:0] rdata1_q, rdata1_d;
  logic [15:0]   conflicts_q, conflicts_d;
  logic          both_req;
  logic          pick1;

`ifdef MYRISC16_ARB_ROUND_ROBIN_EN
  // Port that wins the next contention; flips to the other port on every grant.
  logic          rr_ptr_q, rr_ptr_d;
`else
  localparam logic [3:0] STARVE_LIM_C = 4'(STARVE_LIMIT);
  logic [3:0]    starve_q, starve_d;
`endif

  assign both_req = bus.in_req0 & bus.in_req1;

  always_comb begin
    state_d     = state_q;
    mem_addr_d  = mem_addr_q;
    mem_we_d    = 1'b0;
    mem_wdata_d = mem_wdata_q;
    winner_d    = winner_q;
    rvalid0_d   = 1'b0;
    rvalid1_d   = 1'b0;
    // Read data is captured in the same cycle it is presented as valid.
    rdata0_d    = rvalid0_q ? bus.in_mem_rdata : rdata0_q;
    rdata1_d    = rvalid1_q ? bus.in_mem_rdata : rdata1_q;
    conflicts_d = conflicts_q;
    pick1       = 1'b0;
`ifdef MYRISC16_ARB_ROUND_ROBIN_EN
    rr_ptr_d    = rr_ptr_q;
`else
    starve_d    = starve_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (bus.in_req0 | bus.in_req1) begin
          if (both_req) begin
            if (conflicts_q != 16'hFFFF) begin
              conflicts_d = conflicts_q + 16'd1;
            end
`ifdef MYRISC16_ARB_ROUND_ROBIN_EN
            pick1 = rr_ptr_q;
`else
            if (starve_q == STARVE_LIM_C) begin
              pick1 = 1'b0;
            end else begin
              pick1    = 1'b1;
              starve_d = starve_q + 4'd1;
            end
`endif
          end else begin
            pick1 = bus.in_req1;
          end
`ifdef MYRISC16_ARB_ROUND_ROBIN_EN
          rr_ptr_d = ~pick1;
`else
          if (!pick1) begin
            starve_d = '0;
          end
`endif
          winner_d    = pick1;
          mem_addr_d  = pick1 ? bus.in_addr1  : bus.in_addr0;
          mem_we_d    = pick1 ? bus.in_we1    : bus.in_we0;
          mem_wdata_d = pick1 ? bus.in_wdata1 : bus.in_wdata0;
          state_d     = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        // mem_we_d keeps its default of 0 so the strobe drops on leaving.
        state_d   = ST_IDLE;
        rvalid0_d = ~mem_we_q & ~winner_q;
        rvalid1_d = ~mem_we_q &  winner_q;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge in_clock) begin
    if (in_reset) begin
      state_q     <= ST_IDLE;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      winner_q    <= 1'b0;
      rvalid0_q   <= 1'b0;
      rvalid1_q   <= 1'b0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
      conflicts_q <= '0;
`ifdef MYRISC16_ARB_ROUND_ROBIN_EN
      rr_ptr_q    <= 1'b0;
`else
      starve_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      winner_q    <= winner_d;
      rvalid0_q   <= rvalid0_d;
      rvalid1_q   <= rvalid1_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
      conflicts_q <= conflicts_d;
`ifdef MYRISC16_ARB_ROUND_ROBIN_EN
      rr_ptr_q    <= rr_ptr_d;
`else
      starve_q    <= starve_d;
`endif
    end
  end

  assign bus.out_gnt0      = (state_q == ST_ACCESS) & ~winner_q;
  assign bus.out_gnt1      = (state_q == ST_ACCESS) &  winner_q;
  assign bus.out_rvalid0   = rvalid0_q;
  assign bus.out_rvalid1   = rvalid1_q;
  assign bus.out_rdata0    = rvalid0_q ? bus.in_mem_rdata : rdata0_q;
  assign bus.out_rdata1    = rvalid1_q ? bus.in_mem_rdata : rdata1_q;
  assign bus.out_mem_addr  = mem_addr_q;
  // Gated so a reset landing on an ACCESS cycle can never commit a write.
  assign bus.out_mem_we    = mem_we_q & ~in_reset;
  assign bus.out_mem_wdata = mem_wdata_q;
  assign bus.out_conflicts = conflicts_q;
  assign out_dbg_state     = state_q;

endmodule
